ps2_key_scheduler: RTL and testbench

- Sits downstream of the PS/2 byte receiver and upstream of the four-player game update engine.
- Parses E0/F0 prefix sequences into make/break events for the 17 game keys and keeps a held-key map.
- At a fixed move rate, shares the single move-command port between the four players round-robin over a valid/ready handshake.

---
 rtl/ps2_key_scheduler.sv | 246 ++++++++++++++++++++++++
 tb/tb_ps2_key_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : ps2_key_scheduler                                           |
// | Brief    : PS/2 scan-byte parser, held-key map and round-robin         |
// |            four-player move-command scheduler.                         |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module ps2_key_scheduler #(
    parameter int MOVE_DIV = 2500000,
    parameter int CNT_W    = 22
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        byte_err,
    output logic        cmd_valid,
    output logic [1:0]  cmd_player,
    output logic [1:0]  cmd_dir,
    input  logic        cmd_ready,
    output logic        start_pulse,
    output logic [16:0] keys_held,
    output logic        overrun
);

    localparam logic [1:0] PFX_IDLE    = 2'd0;
    localparam logic [1:0] PFX_EXT     = 2'd1;
    localparam logic [1:0] PFX_BRK     = 2'd2;
    localparam logic [1:0] PFX_EXT_BRK = 2'd3;

    localparam logic ARB_IDLE  = 1'b0;
    localparam logic ARB_OFFER = 1'b1;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(MOVE_DIV - 1);

    logic [1:0]       pfx_q, pfx_d;
    logic             arb_q, arb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [16:0]      keys_held_q, keys_held_d;
    logic             start_pulse_q, start_pulse_d;
    logic [3:0]       pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic [1:0]       rr_q, rr_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [1:0]       cmd_player_q, cmd_player_d;
    logic [1:0]       cmd_dir_q, cmd_dir_d;

    logic       ev_valid, ev_make, ev_ext;
    logic [5:0] key_lookup;
    logic       key_hit;
    logic [4:0] key_idx;
    logic       tick;
    logic [3:0] group_held;
    logic [3:0] grp_keys [4];
    logic       found;
    logic [1:0] sel;
    logic       handshake, issue, drop;
    logic [3:0] clr, pending_after;

    // Returns {hit, index}; hit is 0 for codes outside the game-key set.
    function automatic logic [5:0] key_map(input logic ext, input logic [7:0] code);
        logic [5:0] r;
        r = 6'd0;
        if (ext) begin
            case (code)
                8'h75:   r = {1'b1, 5'd0};
                8'h72:   r = {1'b1, 5'd1};
                8'h6B:   r = {1'b1, 5'd2};
                8'h74:   r = {1'b1, 5'd3};
                default: r = 6'd0;
            endcase
        end else begin
            case (code)
                8'h1D:   r = {1'b1, 5'd4};
                8'h1B:   r = {1'b1, 5'd5};
                8'h1C:   r = {1'b1, 5'd6};
                8'h23:   r = {1'b1, 5'd7};
                8'h35:   r = {1'b1, 5'd8};
                8'h33:   r = {1'b1, 5'd9};
                8'h34:   r = {1'b1, 5'd10};
                8'h3B:   r = {1'b1, 5'd11};
                8'h4D:   r = {1'b1, 5'd12};
                8'h4C:   r = {1'b1, 5'd13};
                8'h4B:   r = {1'b1, 5'd14};
                8'h52:   r = {1'b1, 5'd15};
                8'h29:   r = {1'b1, 5'd16};
                default: r = 6'd0;
            endcase
        end
        return r;
    endfunction

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            pfx_q         <= PFX_IDLE;
            arb_q         <= ARB_IDLE;
            cnt_q         <= '0;
            keys_held_q   <= '0;
            start_pulse_q <= 1'b0;
            pending_q     <= '0;
            overrun_q     <= 1'b0;
            rr_q          <= 2'd3;
            cmd_valid_q   <= 1'b0;
            cmd_player_q  <= 2'd0;
            cmd_dir_q     <= 2'd0;
        end else begin
            pfx_q         <= pfx_d;
            arb_q         <= arb_d;
            cnt_q         <= cnt_d;
            keys_held_q   <= keys_held_d;
            start_pulse_q <= start_pulse_d;
            pending_q     <= pending_d;
            overrun_q     <= overrun_d;
            rr_q          <= rr_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_player_q  <= cmd_player_d;
            cmd_dir_q     <= cmd_dir_d;
        end
    end

    // Prefix parser: decides which bytes become make/break events.
    always_comb begin
        pfx_d    = pfx_q;
        ev_valid = 1'b0;
        ev_make  = 1'b0;
        ev_ext   = 1'b0;
        if (byte_valid) begin
            if (byte_err) begin
                pfx_d = PFX_IDLE;
            end else begin
                case (pfx_q)
                    PFX_IDLE: begin
                        if (byte_data == 8'hE0)      pfx_d = PFX_EXT;
                        else if (byte_data == 8'hF0) pfx_d = PFX_BRK;
                        else begin
                            ev_valid = 1'b1;
                            ev_make  = 1'b1;
                        end
                    end
                    PFX_EXT: begin
                        if (byte_data == 8'hF0)      pfx_d = PFX_EXT_BRK;
                        else if (byte_data == 8'hE0) pfx_d = PFX_EXT;
                        else begin
                            ev_valid = 1'b1;
                            ev_make  = 1'b1;
                            ev_ext   = 1'b1;
                            pfx_d    = PFX_IDLE;
                        end
                    end
                    PFX_BRK: begin
                        pfx_d = PFX_IDLE;
                        if (byte_data != 8'hE0 && byte_data != 8'hF0) ev_valid = 1'b1;
                    end
                    default: begin
                        pfx_d = PFX_IDLE;
                        if (byte_data != 8'hE0 && byte_data != 8'hF0) begin
                            ev_valid = 1'b1;
                            ev_ext   = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign key_lookup = key_map(ev_ext, byte_data);
    assign key_hit    = ev_valid & key_lookup[5];
    assign key_idx    = key_lookup[4:0];

    always_comb begin
        keys_held_d   = keys_held_q;
        start_pulse_d = 1'b0;
        if (key_hit) begin
            keys_held_d[key_idx] = ev_make;
            // Only the edge from released to held counts as a start request.
            if (ev_make && key_idx == 5'd16 && !keys_held_q[16]) start_pulse_d = 1'b1;
        end
    end

    assign tick  = (cnt_q == TICK_LAST);
    assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

    for (genvar g = 0; g < 4; g++) begin : g_grp
        assign grp_keys[g]   = keys_held_q[4*g +: 4];
        assign group_held[g] = |grp_keys[g];
    end

    always_comb begin
        found = 1'b0;
        sel   = rr_q;
        for (int k = 1; k <= 4; k++) begin
            if (!found && pending_q[rr_q + 2'(k)]) begin
                found = 1'b1;
                sel   = rr_q + 2'(k);
            end
        end
    end

    assign handshake = (arb_q == ARB_OFFER) & cmd_valid_q & cmd_ready;
    assign issue     = (arb_q == ARB_IDLE) & found & group_held[sel];
    assign drop      = (arb_q == ARB_IDLE) & found & ~group_held[sel];

    always_comb begin
        arb_d = arb_q;
        case (arb_q)
            ARB_IDLE:  if (issue) arb_d = ARB_OFFER;
            default:   if (handshake) arb_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        clr = 4'b0000;
        if (handshake) clr[cmd_player_q] = 1'b1;
        if (drop)      clr[sel]          = 1'b1;
        // Clears land before the tick sets, so a just-served player is not an overrun.
        pending_after = pending_q & ~clr;
        pending_d     = tick ? (pending_after | group_held) : pending_after;
        overrun_d     = overrun_q | (tick & |(pending_after & group_held));

        rr_d         = rr_q;
        cmd_valid_d  = cmd_valid_q;
        cmd_player_d = cmd_player_q;
        cmd_dir_d    = cmd_dir_q;
        if (issue) begin
            cmd_valid_d  = 1'b1;
            cmd_player_d = sel;
            if (grp_keys[sel][0])      cmd_dir_d = 2'd0;
            else if (grp_keys[sel][1]) cmd_dir_d = 2'd1;
            else if (grp_keys[sel][2]) cmd_dir_d = 2'd2;
            else                       cmd_dir_d = 2'd3;
        end
        if (handshake) begin
            cmd_valid_d = 1'b0;
            rr_d        = cmd_player_q;
        end
    end

    assign cmd_valid   = cmd_valid_q;
    assign cmd_player  = cmd_player_q;
    assign cmd_dir     = cmd_dir_q;
    assign start_pulse = start_pulse_q;
    assign keys_held   = keys_held_q;
    assign overrun     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_ps2_key_scheduler                                        |
// | Brief    : Scoreboard bench for ps2_key_scheduler (MOVE_DIV = 16).     |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_ps2_key_scheduler;

    localparam int MOVE_DIV = 16;
    localparam int CNT_W    = 5;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_err = 1'b0;
    logic        cmd_ready = 1'b1;
    logic        cmd_valid;
    logic [1:0]  cmd_player;
    logic [1:0]  cmd_dir;
    logic        start_pulse;
    logic [16:0] keys_held;
    logic        overrun;

    typedef struct {
        logic [1:0] player;
        logic [1:0] dir;
    } cmd_t;

    cmd_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   pe;
    int   hs_cnt = 0;
    int   pulse_cnt = 0;
    int   hs0;
    logic prev_hs = 1'b0;

    ps2_key_scheduler #(.MOVE_DIV(MOVE_DIV), .CNT_W(CNT_W)) dut (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_err   (byte_err),
        .cmd_valid  (cmd_valid),
        .cmd_player (cmd_player),
        .cmd_dir    (cmd_dir),
        .cmd_ready  (cmd_ready),
        .start_pulse(start_pulse),
        .keys_held  (keys_held),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Posedges since reset release; equals the DUT tick counter modulo MOVE_DIV.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) pe <= 0;
        else         pe <= pe + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic e);
        byte_valid = 1'b1;
        byte_data  = d;
        byte_err   = e;
        step(1);
        byte_valid = 1'b0;
        byte_err   = 1'b0;
    endtask

    task automatic push_exp(input logic [1:0] p, input logic [1:0] d);
        cmd_t c;
        c.player = p;
        c.dir    = d;
        exp_q.push_back(c);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        resetn     = 1'b0;
        byte_valid = 1'b0;
        #1;
        check({tag, "_valid"},   32'(cmd_valid),   32'd0);
        check({tag, "_player"},  32'(cmd_player),  32'd0);
        check({tag, "_dir"},     32'(cmd_dir),     32'd0);
        check({tag, "_pulse"},   32'(start_pulse), 32'd0);
        check({tag, "_keys"},    32'(keys_held),   32'd0);
        check({tag, "_overrun"}, 32'(overrun),     32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        step(1);
    endtask

    task automatic wait_cmd(input string tag, input int budget);
        int n = 0;
        while (!cmd_valid && n < budget) begin
            step(1);
            n++;
        end
        check(tag, 32'(cmd_valid), 32'd1);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step(1);
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: any offered command must match the oldest expected one.
    always @(negedge clk) begin
        if (resetn) begin
            if (prev_hs) check("cmd_gap", 32'(cmd_valid), 32'd0);
            if (cmd_valid) begin
                if (exp_q.size() == 0) begin
                    check("cmd_unexpected", 32'(cmd_valid), 32'd0);
                end else begin
                    check("cmd_player", 32'(cmd_player), 32'(exp_q[0].player));
                    check("cmd_dir",    32'(cmd_dir),    32'(exp_q[0].dir));
                    if (cmd_ready) begin
                        void'(exp_q.pop_front());
                        hs_cnt++;
                    end
                end
            end
            prev_hs = cmd_valid & cmd_ready;
            if (start_pulse) pulse_cnt++;
        end else begin
            prev_hs = 1'b0;
        end
    end

    initial begin
        // Basic make/break and first command latency.
        do_reset("rst0");
        send(8'h1D, 1'b0);
        check("t1_make", 32'(keys_held), 32'h10);
        send(8'hF0, 1'b0);
        send(8'h1D, 1'b0);
        check("t1_break", 32'(keys_held), 32'h0);
        send(8'h1D, 1'b0);
        push_exp(2'd1, 2'd0);
        wait_cmd("t1_cmd", 30);
        check("t1_latency", 32'(pe), 32'd17);
        step(1);
        check("t1_valid_low", 32'(cmd_valid), 32'd0);
        check("t1_drain", 32'(exp_q.size()), 32'd0);
        check("t1_overrun", 32'(overrun), 32'd0);

        // Three players served round-robin from one tick.
        do_reset("rst1");
        hs0 = hs_cnt;
        send(8'hE0, 1'b0);
        send(8'h75, 1'b0);
        send(8'h1B, 1'b0);
        send(8'h35, 1'b0);
        check("t2_keys", 32'(keys_held), 32'h121);
        push_exp(2'd0, 2'd0);
        push_exp(2'd1, 2'd1);
        push_exp(2'd2, 2'd0);
        wait_drain("t2_drain", 40);
        check("t2_hs", 32'(hs_cnt - hs0), 32'd3);

        // Direction priority and extended break.
        do_reset("rst2");
        send(8'hE0, 1'b0);
        send(8'h74, 1'b0);
        send(8'hE0, 1'b0);
        send(8'h6B, 1'b0);
        check("t3_keys", 32'(keys_held), 32'h0C);
        push_exp(2'd0, 2'd2);
        wait_drain("t3_drain_a", 30);
        send(8'hE0, 1'b0);
        send(8'hF0, 1'b0);
        send(8'h6B, 1'b0);
        check("t3_ext_break", 32'(keys_held), 32'h08);
        push_exp(2'd0, 2'd3);
        wait_drain("t3_drain_b", 30);

        // Backpressure: command held stable, overrun on the next tick.
        do_reset("rst3");
        cmd_ready = 1'b0;
        hs0 = hs_cnt;
        send(8'h1C, 1'b0);
        push_exp(2'd1, 2'd2);
        wait_cmd("t4_cmd", 30);
        check("t4_overrun_pre", 32'(overrun), 32'd0);
        step(40);
        check("t4_valid_held", 32'(cmd_valid), 32'd1);
        check("t4_overrun", 32'(overrun), 32'd1);
        check("t4_no_hs", 32'(hs_cnt - hs0), 32'd0);
        cmd_ready = 1'b1;
        step(3);
        check("t4_one_hs", 32'(hs_cnt - hs0), 32'd1);
        check("t4_valid_low", 32'(cmd_valid), 32'd0);

        // SPACE start pulses, ignored ext/err bytes.
        do_reset("rst4");
        pulse_cnt = 0;
        send(8'h29, 1'b0);
        check("t5_pulse1", 32'(start_pulse), 32'd1);
        send(8'h29, 1'b0);
        check("t5_typ1", 32'(start_pulse), 32'd0);
        send(8'h29, 1'b0);
        check("t5_typ2", 32'(start_pulse), 32'd0);
        send(8'hF0, 1'b0);
        send(8'h29, 1'b0);
        check("t5_brk_pulse", 32'(start_pulse), 32'd0);
        check("t5_brk_keys", 32'(keys_held), 32'h0);
        send(8'h29, 1'b0);
        check("t5_pulse2", 32'(start_pulse), 32'd1);
        send(8'hF0, 1'b0);
        send(8'h29, 1'b0);
        send(8'hE0, 1'b0);
        send(8'h29, 1'b0);
        check("t5_ext29_pulse", 32'(start_pulse), 32'd0);
        check("t5_ext29_keys", 32'(keys_held), 32'h0);
        send(8'h29, 1'b1);
        check("t5_err_pulse", 32'(start_pulse), 32'd0);
        check("t5_err_keys", 32'(keys_held), 32'h0);
        send(8'hE0, 1'b0);
        send(8'h1D, 1'b1);
        send(8'h75, 1'b0);
        check("t5_err_drops_ext", 32'(keys_held), 32'h0);
        step(2);
        check("t5_pulse_total", 32'(pulse_cnt), 32'd2);

        // Reset while a command is offered and a prefix is half parsed.
        do_reset("rst5");
        cmd_ready = 1'b0;
        send(8'h1D, 1'b0);
        push_exp(2'd1, 2'd0);
        wait_cmd("t6_cmd", 30);
        send(8'hE0, 1'b0);
        do_reset("t6_mid");
        cmd_ready = 1'b1;
        send(8'h75, 1'b0);
        check("t6_75_ignored", 32'(keys_held), 32'h0);
        step(2);
        check("t6_no_cmd", 32'(cmd_valid), 32'd0);

        check("final_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
